// File: rtl/poets_dbg_pkg.sv
// Shared types and constants for the system-clock side of the debug slave.
// Latency: none; this package holds declarations only.
// Backpressure: none; it is not a datapath element.
package poets_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } dbg_state_t;

    // Virtual-JTAG instruction opcodes carried on cmd_ir
    localparam int IR_OCIMEM    = 0;
    localparam int IR_TRACEMEM  = 1;
    localparam int IR_BREAK     = 2;
    localparam int IR_TRACECTRL = 3;

    // Readback word returned when a command times out
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_0000;

    // Shift register layout: {bcast, sel[SEL_W-1:0], payload[DR_W-1:0]}
    function automatic int sr_sel_lsb(input int dr_w);
        return dr_w;
    endfunction

    function automatic int sr_bcast_bit(input int dr_w, input int sel_w);
        return dr_w + sel_w;
    endfunction

endpackage

// File: rtl/poets_dbg_tog_sync.sv
// Brings a TCK-domain toggle into clk and emits a one-cycle event per flip.
// Latency: event acted on at the 3rd clk edge after the toggle changes.
// Backpressure: none; every toggle flip yields exactly one event.
module poets_dbg_tog_sync (
    input  logic clk,
    input  logic reset,
    input  logic tog,
    output logic evt
);

    logic s1;
    logic s2;
    logic s3;

    // Two metastability stages followed by the edge-detect history flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tog;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign evt = s2 ^ s3;

endmodule

// File: rtl/poets_debug_slave_sysclk_mc.sv
// Decodes update-DR events into per-channel OCI commands and returns readback via toggle.
// Latency: 3-cycle sync + >=1 DISPATCH + >=1 WAIT_RSP + 1 DONE; build option POETS_DBG_BROADCAST_EN.
// Backpressure: per-channel cmd_valid/cmd_ready; updates arriving while busy are dropped and flagged.
module poets_debug_slave_sysclk_mc
    import poets_dbg_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int SEL_W       = 2,
    parameter int RD_W        = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   uir_tog,
    input  logic                   udr_tog,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [DR_W+SEL_W:0]    sr,
    output logic [DR_W-1:0]        jdo,
    output logic [NUM_CH-1:0]      cmd_valid,
    output logic [IR_W-1:0]        cmd_ir,
    input  logic [NUM_CH-1:0]      cmd_ready,
    input  logic [NUM_CH-1:0]      rsp_valid,
    input  logic [NUM_CH*RD_W-1:0] rsp_data,
    output logic [RD_W-1:0]        rd_data,
    output logic                   rd_tog,
    output logic                   st_busy,
    output logic                   err_overrun,
    output logic                   err_timeout,
    input  logic                   err_clr
);

    localparam int               SEL_LSB   = sr_sel_lsb(DR_W);
    localparam int               BC_BIT    = sr_bcast_bit(DR_W, SEL_W);
    localparam logic [15:0]      TMO_LIMIT = 16'(TIMEOUT_CYC);
    localparam logic [RD_W+31:0] FILL_EXT  = {{RD_W{1'b0}}, TIMEOUT_FILL};
    localparam logic [RD_W-1:0]  FILL      = FILL_EXT[RD_W-1:0];

    dbg_state_t        state_q;
    dbg_state_t        state_nxt;
    logic              uir_evt;
    logic              udr_evt;
    logic [IR_W-1:0]   ir_q;
    logic [IR_W-1:0]   cmd_ir_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] prim_q;
    logic              bad_q;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_nxt;
    logic              tmo;
    logic              rsp_hit;
    logic [RD_W-1:0]   rsp_sel;
    logic [SEL_W-1:0]  sr_sel;
    logic              sr_bc;
    logic [NUM_CH-1:0] sel_oh;

    poets_dbg_tog_sync u_uir_sync (.clk(clk), .reset(reset), .tog(uir_tog), .evt(uir_evt));
    poets_dbg_tog_sync u_udr_sync (.clk(clk), .reset(reset), .tog(udr_tog), .evt(udr_evt));

    assign sr_sel = sr[SEL_LSB +: SEL_W];

`ifdef POETS_DBG_BROADCAST_EN
    assign sr_bc = sr[BC_BIT];
`else
    // Broadcast bit is carried in the shift register but has no effect in this build
    logic sr_bc_unused;
    assign sr_bc_unused = sr[BC_BIT];
    assign sr_bc        = 1'b0;
`endif

    // One-hot decode of the channel select; all-zero means select is out of range
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_oh[i] = (sr_sel == SEL_W'(i));
        end
    end

    // Readback mux and strobe from the primary channel only
    always_comb begin
        rsp_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (prim_q[i]) begin
                rsp_sel = rsp_sel | rsp_data[i*RD_W +: RD_W];
            end
        end
    end

    assign rsp_hit = |(rsp_valid & prim_q);

    // State and timeout counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state logic; the counter restarts on entry to DISPATCH and to WAIT_RSP
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + 16'd1;
        tmo       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (udr_evt) begin
                    state_nxt = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (bad_q) begin
                    state_nxt = ST_DONE;
                end else if (pend_q == '0) begin
                    state_nxt = ST_WAIT_RSP;
                    cnt_nxt   = '0;
                end else if (cnt_nxt == TMO_LIMIT) begin
                    tmo       = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_hit) begin
                    state_nxt = ST_DONE;
                end else if (cnt_nxt == TMO_LIMIT) begin
                    tmo       = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command capture, per-channel accept tracking, readback and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q        <= '0;
            cmd_ir_q    <= '0;
            jdo         <= '0;
            pend_q      <= '0;
            prim_q      <= '0;
            bad_q       <= 1'b0;
            rd_data     <= '0;
            rd_tog      <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (uir_evt) begin
                ir_q <= ir_in;
            end

            if (state_q == ST_IDLE && udr_evt) begin
                jdo      <= sr[DR_W-1:0];
                cmd_ir_q <= ir_q;
                pend_q   <= sr_bc ? '1 : sel_oh;
                prim_q   <= sr_bc ? NUM_CH'(1) : sel_oh;
                bad_q    <= !sr_bc && (sel_oh == '0);
            end else if (state_q == ST_DISPATCH) begin
                pend_q <= tmo ? '0 : (pend_q & ~cmd_ready);
            end

            if (state_q == ST_DISPATCH && bad_q) begin
                rd_data <= '1;
            end else if (tmo) begin
                rd_data <= FILL;
            end else if (state_q == ST_WAIT_RSP && rsp_hit) begin
                rd_data <= rsp_sel;
            end

            if (state_q == ST_DONE) begin
                rd_tog <= ~rd_tog;
            end

            if (udr_evt && state_q != ST_IDLE) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end

            if (tmo) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

    assign cmd_valid = (state_q == ST_DISPATCH) ? pend_q : '0;
    assign cmd_ir    = cmd_ir_q;
    assign st_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_poets_debug_slave_sysclk_mc.sv
// Bench for the debug slave: directed commands, CPU responder model, queue-based checking.
// Latency: expectations are queued at issue time and popped when the DUT presents them.
// Backpressure: responder drives cmd_ready after a per-channel delay; -1 never accepts.
module tb_poets_debug_slave_sysclk_mc;

    localparam int NCH  = 3;
    localparam int IRW  = 2;
    localparam int DRW  = 38;
    localparam int SELW = 2;
    localparam int RDW  = 32;
    localparam int TMO  = 15;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 uir_tog;
    logic                 udr_tog;
    logic [IRW-1:0]       ir_in;
    logic [DRW+SELW:0]    sr;
    logic [DRW-1:0]       jdo;
    logic [NCH-1:0]       cmd_valid;
    logic [IRW-1:0]       cmd_ir;
    logic [NCH-1:0]       cmd_ready;
    logic [NCH-1:0]       rsp_valid;
    logic [NCH*RDW-1:0]   rsp_data;
    logic [RDW-1:0]       rd_data;
    logic                 rd_tog;
    logic                 st_busy;
    logic                 err_overrun;
    logic                 err_timeout;
    logic                 err_clr;

    typedef struct packed {
        logic [NCH-1:0] mask;
        logic [DRW-1:0] jdo;
        logic [IRW-1:0] ir;
    } cmd_exp_t;

    cmd_exp_t       cmd_q[$];
    logic [RDW-1:0] rd_q[$];

    int             n_run  = 0;
    int             n_fail = 0;
    int             rdy_dly[NCH];
    int             rsp_dly[NCH];
    logic [RDW-1:0] rsp_word[NCH];
    int             vcnt[NCH];
    int             rcnt[NCH];
    logic [NCH-1:0] v_prev;
    int             lat;
    int             n;

    assign rsp_data = {rsp_word[2], rsp_word[1], rsp_word[0]};

    always #5 clk = ~clk;

    poets_debug_slave_sysclk_mc #(
        .NUM_CH(NCH), .IR_W(IRW), .DR_W(DRW), .SEL_W(SELW), .RD_W(RDW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .uir_tog(uir_tog), .udr_tog(udr_tog), .ir_in(ir_in), .sr(sr),
        .jdo(jdo), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rd_data(rd_data), .rd_tog(rd_tog),
        .st_busy(st_busy), .err_overrun(err_overrun), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [IRW-1:0] ir, input logic bc, input logic [SELW-1:0] sel,
                         input logic [DRW-1:0] pl);
        ir_in   = ir;
        uir_tog = ~uir_tog;
        repeat (4) step();
        sr      = {bc, sel, pl};
        udr_tog = ~udr_tog;
    endtask

    // Returns the number of cycles until cmd_valid appears, or -1
    task automatic wait_cmd(output int l);
        l = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (cmd_valid != '0) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        repeat (4) step();
        for (int i = 0; i < 200; i++) begin
            if (!st_busy) break;
            step();
        end
        check(name, st_busy, 0);
        repeat (2) step();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
    endtask

    // CPU model: accepts after rdy_dly cycles of valid, answers rsp_dly cycles after accept
    initial begin : cpu
        cmd_ready = '0;
        rsp_valid = '0;
        v_prev    = '0;
        for (int c = 0; c < NCH; c++) begin
            vcnt[c] = 0;
            rcnt[c] = 0;
        end
        forever begin
            step();
            rsp_valid = '0;
            for (int c = 0; c < NCH; c++) begin
                if (rcnt[c] > 0) begin
                    rcnt[c]--;
                    if (rcnt[c] == 0) rsp_valid[c] = 1'b1;
                end
                if (v_prev[c] && cmd_ready[c] && !reset) begin
                    cmd_ready[c] = 1'b0;
                    vcnt[c]      = 0;
                    rcnt[c]      = rsp_dly[c];
                end else if (cmd_valid[c]) begin
                    vcnt[c]++;
                    if (rdy_dly[c] >= 0 && vcnt[c] >= rdy_dly[c]) cmd_ready[c] = 1'b1;
                end else begin
                    vcnt[c]      = 0;
                    cmd_ready[c] = 1'b0;
                end
            end
            v_prev = cmd_valid;
        end
    end

    // Command monitor: every new command start is compared against the queue head
    initial begin : mon_cmd
        logic [NCH-1:0] prev;
        cmd_exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (cmd_valid != '0 && prev == '0) begin
                if (cmd_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL cmd_unexpected: got mask 0x%0h, expected no command", cmd_valid);
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_mask", 64'(cmd_valid), 64'(e.mask));
                    check("cmd_jdo", 64'(jdo), 64'(e.jdo));
                    check("cmd_ir", 64'(cmd_ir), 64'(e.ir));
                end
            end
            prev = cmd_valid;
        end
    end

    // Readback monitor: each rd_tog flip outside reset must carry the next expected word
    initial begin : mon_rd
        logic prev;
        logic [RDW-1:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = rd_tog;
            end else if (rd_tog != prev) begin
                prev = rd_tog;
                if (rd_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got rd_data 0x%0h, expected no flip", rd_data);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_data", 64'(rd_data), 64'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        reset   = 1'b1;
        uir_tog = 1'b0;
        udr_tog = 1'b0;
        ir_in   = '0;
        sr      = '0;
        err_clr = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            rdy_dly[c]  = -1;
            rsp_dly[c]  = 1;
            rsp_word[c] = '0;
        end
        repeat (3) step();
        check("rst_cmd_valid", 64'(cmd_valid), 0);
        check("rst_jdo", 64'(jdo), 0);
        check("rst_rd_data", 64'(rd_data), 0);
        check("rst_rd_tog", 64'(rd_tog), 0);
        check("rst_busy", 64'(st_busy), 0);
        check("rst_errs", 64'({err_overrun, err_timeout}), 0);
        reset = 1'b0;
        repeat (2) step();

        // Unicast to channel 1
        rdy_dly  = '{-1, 2, -1};
        rsp_dly  = '{1, 1, 1};
        rsp_word = '{32'hAAAA_0000, 32'h1234_5678, 32'hCCCC_0002};
        cmd_q.push_back('{mask: 3'b010, jdo: 38'h15, ir: 2'd2});
        rd_q.push_back(32'h1234_5678);
        issue(2'd2, 1'b0, 2'd1, 38'h15);
        wait_cmd(lat);
        check("t1_cmd_within4", 64'(lat >= 1 && lat <= 4), 1);
        wait_idle("t1_idle");
        check("t1_errs", 64'({err_overrun, err_timeout}), 0);

        // Broadcast request with staggered accepts
        rdy_dly  = '{1, 3, 5};
        rsp_dly  = '{8, 1, 1};
        rsp_word = '{32'h0A0A_0A0A, 32'h1B1B_1B1B, 32'h2C2C_2C2C};
`ifdef POETS_DBG_BROADCAST_EN
        cmd_q.push_back('{mask: 3'b111, jdo: 38'h20_0000_0001, ir: 2'd0});
        rd_q.push_back(32'h0A0A_0A0A);
`else
        cmd_q.push_back('{mask: 3'b010, jdo: 38'h20_0000_0001, ir: 2'd0});
        rd_q.push_back(32'h1B1B_1B1B);
`endif
        issue(2'd0, 1'b1, 2'd1, 38'h20_0000_0001);
        wait_cmd(lat);
`ifdef POETS_DBG_BROADCAST_EN
        step();
        check("t2_ch0_drop", 64'(cmd_valid), 64'(3'b110));
        repeat (2) step();
        check("t2_ch1_drop", 64'(cmd_valid), 64'(3'b100));
        repeat (2) step();
        check("t2_ch2_drop", 64'(cmd_valid), 64'(3'b000));
`endif
        wait_idle("t2_idle");

        // Second update-DR while waiting for the response
        rdy_dly     = '{1, -1, -1};
        rsp_dly     = '{10, 1, 1};
        rsp_word[0] = 32'h600D_F00D;
        cmd_q.push_back('{mask: 3'b001, jdo: 38'h33, ir: 2'd1});
        rd_q.push_back(32'h600D_F00D);
        issue(2'd1, 1'b0, 2'd0, 38'h33);
        wait_cmd(lat);
        repeat (2) step();
        ir_in   = 2'd3;
        uir_tog = ~uir_tog;
        udr_tog = ~udr_tog;
        wait_idle("t3_idle");
        check("t3_overrun_set", 64'(err_overrun), 1);
        check("t3_ir_kept", 64'(cmd_ir), 1);
        pulse_clr();
        check("t3_overrun_clr", 64'(err_overrun), 0);

        // Channel never accepts: timeout abort
        rdy_dly = '{-1, -1, -1};
        cmd_q.push_back('{mask: 3'b100, jdo: 38'h44, ir: 2'd3});
        rd_q.push_back(32'hDEAD_0000);
        issue(2'd3, 1'b0, 2'd2, 38'h44);
        wait_cmd(lat);
        n = 0;
        while (cmd_valid != '0 && n < 40) begin
            n++;
            step();
        end
        check("t4_valid_cycles", 64'(n), 64'(TMO));
        wait_idle("t4_idle");
        check("t4_timeout_set", 64'(err_timeout), 1);
        pulse_clr();
        check("t4_timeout_clr", 64'(err_timeout), 0);

        // Select beyond the channel count
        rd_q.push_back(32'hFFFF_FFFF);
        issue(2'd0, 1'b0, 2'd3, 38'h55);
        wait_idle("t5_idle");
        check("t5_no_timeout", 64'(err_timeout), 0);

        // Reset while dispatching, then a clean command
        cmd_q.push_back('{mask: 3'b001, jdo: 38'h66, ir: 2'd2});
        issue(2'd2, 1'b0, 2'd0, 38'h66);
        wait_cmd(lat);
        repeat (2) step();
        reset   = 1'b1;
        udr_tog = 1'b0;
        uir_tog = 1'b0;
        #2;
        check("t6_rst_valid", 64'(cmd_valid), 0);
        check("t6_rst_busy", 64'(st_busy), 0);
        check("t6_rst_tog", 64'(rd_tog), 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        rdy_dly     = '{1, -1, -1};
        rsp_dly     = '{2, 1, 1};
        rsp_word[0] = 32'h7777_8888;
        cmd_q.push_back('{mask: 3'b001, jdo: 38'h77, ir: 2'd1});
        rd_q.push_back(32'h7777_8888);
        issue(2'd1, 1'b0, 2'd0, 38'h77);
        wait_cmd(lat);
        check("t6_cmd_after_rst", 64'(lat >= 1 && lat <= 4), 1);
        wait_idle("t6_idle");

        repeat (4) step();
        check("cmd_queue_drained", 64'(cmd_q.size()), 0);
        check("rd_queue_drained", 64'(rd_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
